// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register for CH write channels, with a 2-entry skid buffer and synchronous flush.
// Latency 1 cycle when empty; mem_ready drops only while the skid entry is occupied, so nothing accepted is lost.
// Optional HI/LO write path is enabled with MEM_WB_HILO_EN.
module mem_wb_pipe #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int CH         = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [CH*REG_ADDR_W-1:0] mem_wd,
  input  logic [CH-1:0]           mem_wreg,
  input  logic [CH*DATA_W-1:0]    mem_wdata,
`ifdef MEM_WB_HILO_EN
  input  logic                    mem_whilo,
  input  logic [DATA_W-1:0]       mem_hi,
  input  logic [DATA_W-1:0]       mem_lo,
  output logic                    wb_whilo,
  output logic [DATA_W-1:0]       wb_hi,
  output logic [DATA_W-1:0]       wb_lo,
`endif
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [CH*REG_ADDR_W-1:0] wb_wd,
  output logic [CH-1:0]           wb_wreg,
  output logic [CH*DATA_W-1:0]    wb_wdata
);

`ifdef MEM_WB_HILO_EN
  localparam int PW = CH*REG_ADDR_W + CH + CH*DATA_W + 1 + 2*DATA_W;
`else
  localparam int PW = CH*REG_ADDR_W + CH + CH*DATA_W;
`endif

  logic          main_valid, skid_valid;
  logic [PW-1:0] in_pay, main_pay, skid_pay;
  logic [CH-1:0] main_wreg;
  logic          accept, consume;

`ifdef MEM_WB_HILO_EN
  logic main_whilo;
  assign in_pay = {mem_whilo, mem_hi, mem_lo, mem_wd, mem_wreg, mem_wdata};
  assign {main_whilo, wb_hi, wb_lo, wb_wd, main_wreg, wb_wdata} = main_pay;
  assign wb_whilo = main_whilo & main_valid;
`else
  assign in_pay = {mem_wd, mem_wreg, mem_wdata};
  assign {wb_wd, main_wreg, wb_wdata} = main_pay;
`endif

  // Ready depends only on the skid flop, breaking any combinational path from wb_ready.
  assign mem_ready = !skid_valid;
  assign accept    = mem_valid && mem_ready;
  assign consume   = main_valid && wb_ready;
  assign wb_valid  = main_valid;
  assign wb_wreg   = main_wreg & {CH{main_valid}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_pay   <= '0;
      skid_pay   <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || consume) begin
      if (skid_valid) begin
        main_pay   <= skid_pay;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_pay   <= in_pay;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      // Main is stalled: park the new entry behind it.
      skid_pay   <= in_pay;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe (CH=2): directed reset/stream/stall/flush/async-reset steps, then random traffic,
// all checked against a queue model of at most two in-flight entries.
module tb_mem_wb_pipe;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CH = 2;

  logic clk = 1'b0;
  logic rst, flush, mem_valid, mem_ready, wb_valid, wb_ready;
  logic [CH*AW-1:0] mem_wd, wb_wd;
  logic [CH-1:0]    mem_wreg, wb_wreg;
  logic [CH*DW-1:0] mem_wdata, wb_wdata;
`ifdef MEM_WB_HILO_EN
  logic          mem_whilo, wb_whilo;
  logic [DW-1:0] mem_hi, mem_lo, wb_hi, wb_lo;
`endif

  mem_wb_pipe #(.REG_ADDR_W(AW), .DATA_W(DW), .CH(CH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
`ifdef MEM_WB_HILO_EN
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
`endif
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH*AW-1:0] wd;
    logic [CH-1:0]    wreg;
    logic [CH*DW-1:0] wdata;
    logic             whilo;
    logic [DW-1:0]    hi;
    logic [DW-1:0]    lo;
  } ent_t;

  // Reference: the pipe is an in-order queue holding at most two entries.
  ent_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ent_t cur_in();
    ent_t e;
    e.wd = mem_wd; e.wreg = mem_wreg; e.wdata = mem_wdata;
`ifdef MEM_WB_HILO_EN
    e.whilo = mem_whilo; e.hi = mem_hi; e.lo = mem_lo;
`else
    e.whilo = 1'b0; e.hi = '0; e.lo = '0;
`endif
    return e;
  endfunction

  task automatic check_outs();
    chk("mem_ready", 64'(mem_ready), 64'(q.size() < 2));
    chk("wb_valid", 64'(wb_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("wb_wd", 64'(wb_wd), 64'(q[0].wd));
      chk("wb_wreg", 64'(wb_wreg), 64'(q[0].wreg));
      chk("wb_wdata", 64'(wb_wdata), 64'(q[0].wdata));
`ifdef MEM_WB_HILO_EN
      chk("wb_whilo", 64'(wb_whilo), 64'(q[0].whilo));
      chk("wb_hi", 64'(wb_hi), 64'(q[0].hi));
      chk("wb_lo", 64'(wb_lo), 64'(q[0].lo));
`endif
    end else begin
      chk("wb_wreg_bubble", 64'(wb_wreg), 64'd0);
`ifdef MEM_WB_HILO_EN
      chk("wb_whilo_bubble", 64'(wb_whilo), 64'd0);
`endif
    end
  endtask

  // Check outputs, then clock one edge and advance the model with the inputs seen at that edge.
  task automatic tick(output bit acc);
    bit   cons, fl;
    ent_t e;
    check_outs();
    fl   = flush;
    acc  = mem_valid && (q.size() < 2) && !fl;
    cons = (q.size() > 0) && wb_ready;
    e    = cur_in();
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
  endtask

  task automatic drive(input bit v, input logic [CH*AW-1:0] wd, input logic [CH-1:0] wreg,
                       input logic [CH*DW-1:0] data);
    mem_valid = v; mem_wd = wd; mem_wreg = wreg; mem_wdata = data;
  endtask

  task automatic drive_hilo(input bit w, input logic [DW-1:0] hi, input logic [DW-1:0] lo);
`ifdef MEM_WB_HILO_EN
    mem_whilo = w; mem_hi = hi; mem_lo = lo;
`else
    if (w && (hi != lo)) begin end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    bit got_c;
    flush = 1'b0; wb_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    drive_hilo(1'b0, '0, '0);

    // Reset held with random inputs toggling.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(1'($urandom), CH*AW'($urandom), CH'($urandom), {$urandom, $urandom});
      drive_hilo(1'($urandom), $urandom, $urandom);
      wb_ready = 1'($urandom); flush = 1'($urandom);
      #1;
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      chk("rst_wb_wreg", 64'(wb_wreg), 64'd0);
      chk("rst_wb_wd", 64'(wb_wd), 64'd0);
      chk("rst_wb_wdata", 64'(wb_wdata), 64'd0);
      chk("rst_mem_ready", 64'(mem_ready), 64'd1);
`ifdef MEM_WB_HILO_EN
      chk("rst_wb_whilo", 64'(wb_whilo), 64'd0);
      chk("rst_wb_hi", 64'(wb_hi), 64'd0);
      chk("rst_wb_lo", 64'(wb_lo), 64'd0);
`endif
    end
    flush = 1'b0; wb_ready = 1'b1;
    rst = 1'b1;
    drive(1'b1, {5'd9, 5'd7}, 2'b01, {32'hCAFE_0001, 32'h0BAD_F00D});
    drive_hilo(1'b0, '0, '0);
    tick(acc);
    drive(1'b0, '0, '0, '0);
    tick(acc);
    tick(acc);

    // Streaming, back to back.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, {5'(5 + i), 5'(1 + i)}, 2'b11, {32'(32'hA1 + i), 32'(32'h11 * (i + 1))});
      tick(acc);
    end
    drive(1'b0, '0, '0, '0);
    tick(acc);
    tick(acc);

    // Stall and skid: A, B parked, C held off.
    wb_ready = 1'b0;
    drive(1'b1, {5'd0, 5'd3}, 2'b01, {32'h0, 32'hDEAD_BEEF});
    drive_hilo(1'b1, 32'h1, 32'h2);
    tick(acc);
    drive(1'b1, {5'd0, 5'd4}, 2'b01, {32'h0, 32'h1234_5678});
    drive_hilo(1'b0, '0, '0);
    tick(acc);
    drive(1'b1, {5'd6, 5'd6}, 2'b11, {32'h6666_0002, 32'h6666_0001});
    tick(acc);
    tick(acc);
    wb_ready = 1'b1;
    got_c = 1'b0;
    for (int i = 0; i < 6 && !got_c; i++) begin
      tick(acc);
      got_c = acc;
    end
    checks++;
    if (!got_c) begin
      errors++;
      $error("FAIL stall_c_accept: observed not accepted expected accepted");
    end
    drive(1'b0, '0, '0, '0);
    for (int i = 0; i < 4; i++) tick(acc);

    // Flush with both entries full and a concurrent D.
    wb_ready = 1'b0;
    drive(1'b1, {5'd1, 5'd2}, 2'b10, {32'h1, 32'h2});
    drive_hilo(1'b1, 32'h55, 32'h66);
    tick(acc);
    drive(1'b1, {5'd3, 5'd4}, 2'b11, {32'h3, 32'h4});
    tick(acc);
    flush = 1'b1;
    drive(1'b1, {5'd31, 5'd31}, 2'b11, {32'hD, 32'hD});
    tick(acc);
    flush = 1'b0; wb_ready = 1'b1;
    drive(1'b0, '0, '0, '0);
    drive_hilo(1'b0, '0, '0);
    for (int i = 0; i < 3; i++) tick(acc);

    // Async reset while two entries are stalled.
    wb_ready = 1'b0;
    drive(1'b1, {5'd10, 5'd11}, 2'b11, {32'hAAAA, 32'hBBBB});
    tick(acc);
    drive(1'b1, {5'd12, 5'd13}, 2'b11, {32'hCCCC, 32'hDDDD});
    tick(acc);
    drive(1'b0, '0, '0, '0);
    chk("pre_arst_wb_valid", 64'(wb_valid), 64'd1);
    rst = 1'b0;
    #1;
    chk("arst_wb_valid", 64'(wb_valid), 64'd0);
    chk("arst_wb_wreg", 64'(wb_wreg), 64'd0);
    chk("arst_mem_ready", 64'(mem_ready), 64'd1);
    #1;
    rst = 1'b1;
    q.delete();
    wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick(acc);

    // Random traffic, including flushes, all-zero write enables and colliding addresses.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)),
            {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))},
            CH'($urandom), {$urandom, $urandom});
      drive_hilo(1'($urandom), $urandom, $urandom);
      wb_ready = ($urandom % 4) != 0;
      flush = ($urandom % 20) == 0;
      tick(acc);
    end
    flush = 1'b0; wb_ready = 1'b1;
    drive(1'b0, '0, '0, '0);
    for (int i = 0; i < 4; i++) tick(acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
